// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for the single-cycle ARM datapath.
// Presents the PC to instruction memory, qualifies the returned word and
// supplies PC+4 (link) and PC+8 (R15 read value). Handles stall, branch
// redirect, halt on an all-zero word and a sticky misaligned-target fault.
module pc_fetch_unit #(
  parameter int unsigned          DATAWIDTH    = 32,
  parameter logic [DATAWIDTH-1:0] RESET_VECTOR = 32'h20004000,
  parameter bit                   HALT_ON_ZERO = 1'b1,
  parameter int unsigned          CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [DATAWIDTH-1:0] branch_target,
  input  logic [DATAWIDTH-1:0] instr_in,
  output logic [DATAWIDTH-1:0] inst_address,
  output logic [DATAWIDTH-1:0] instr_out,
  output logic                 instr_valid,
  output logic [DATAWIDTH-1:0] pc_plus4,
  output logic [DATAWIDTH-1:0] pc_plus8,
  output logic                 halted,
  output logic                 misaligned_err,
  output logic [CNT_W-1:0]     fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt, StFault} state_e;

  state_e               state_q;
  logic [DATAWIDTH-1:0] pc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 halted_q;
  logic                 fault_q;

  logic                 word_zero;
  logic                 tgt_misaligned;
  logic [CNT_W-1:0]     cnt_next;

  // Decode of the current fetch and the saturating counter increment
  always_comb begin
    word_zero      = HALT_ON_ZERO && (instr_in == '0);
    tgt_misaligned = (branch_target[1:0] != 2'b00);
    cnt_next       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Fetch FSM with registered PC, counter and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StBoot;
      pc_q     <= RESET_VECTOR;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      unique case (state_q)
        // One settling cycle after reset; PC is not advanced
        StBoot: state_q <= StRun;
        StRun: begin
          // Stall drops the branch request; the requester must hold it
          if (!stall) begin
            if (word_zero) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else if (branch_taken && tgt_misaligned) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else if (branch_taken) begin
              pc_q  <= branch_target;
              cnt_q <= cnt_next;
            end else begin
              pc_q  <= pc_q + DATAWIDTH'(4);
              cnt_q <= cnt_next;
            end
          end
        end
        // Terminal until reset
        StHalt:  ;
        StFault: ;
        default: ;
      endcase
    end
  end

  // Word qualification and PC-relative values from registered state
  always_comb begin
    instr_valid = (state_q == StRun) && !word_zero;
    instr_out   = instr_valid ? instr_in : '0;
    pc_plus4    = pc_q + DATAWIDTH'(4);
    pc_plus8    = pc_q + DATAWIDTH'(8);
  end

  assign inst_address   = pc_q;
  assign halted         = halted_q;
  assign misaligned_err = fault_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: scoreboarded free-run, branch, stall,
// fault and halt sequences on the default build, plus a HALT_ON_ZERO=0 build
// with a narrow counter for wrap, saturation and mid-cycle reset.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h20004000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic [31:0] instr_in, inst_address, instr_out, pc_plus4, pc_plus8;
  logic        instr_valid, halted, misaligned_err;
  logic [15:0] fetch_count;

  logic [31:0] nz_instr_in, nz_inst_address, nz_instr_out, nz_pc_plus4, nz_pc_plus8;
  logic        nz_instr_valid, nz_halted, nz_misaligned_err;
  logic [3:0]  nz_fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic [31:0] p8;
    logic        valid;
    logic        halted;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  typedef enum logic [1:0] {MBoot, MRun, MHalt, MFault} mstate_e;

  exp_t        sb_q[$];
  mstate_e     m_state;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  // Default memory image: non-zero words 0x20004000..0x20004030, zero elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= RV && a <= 32'h20004030) return {8'hE2, a[23:0]};
    return 32'h0;
  endfunction

  assign instr_in    = mem_word(inst_address);
  assign nz_instr_in = 32'h0;

  pc_fetch_unit u_dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .instr_in       (instr_in),
    .inst_address   (inst_address),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .pc_plus4       (pc_plus4),
    .pc_plus8       (pc_plus8),
    .halted         (halted),
    .misaligned_err (misaligned_err),
    .fetch_count    (fetch_count)
  );

  pc_fetch_unit #(
    .HALT_ON_ZERO (1'b0),
    .CNT_W        (4)
  ) u_nz (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .instr_in       (nz_instr_in),
    .inst_address   (nz_inst_address),
    .instr_out      (nz_instr_out),
    .instr_valid    (nz_instr_valid),
    .pc_plus4       (nz_pc_plus4),
    .pc_plus8       (nz_pc_plus8),
    .halted         (nz_halted),
    .misaligned_err (nz_misaligned_err),
    .fetch_count    (nz_fetch_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_state = MBoot;
    m_pc    = RV;
    m_cnt   = 16'd0;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.pc     = m_pc;
    e.valid  = (m_state == MRun) && (mem_word(m_pc) != 32'h0);
    e.instr  = e.valid ? mem_word(m_pc) : 32'h0;
    e.p4     = m_pc + 32'd4;
    e.p8     = m_pc + 32'd8;
    e.halted = (m_state == MHalt);
    e.err    = (m_state == MFault);
    e.cnt    = m_cnt;
    return e;
  endfunction

  // Drive one cycle of stimulus, predict, then compare after the edge
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    exp_t e;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    case (m_state)
      MBoot: m_state = MRun;
      MRun: begin
        if (!s) begin
          if (mem_word(m_pc) == 32'h0) m_state = MHalt;
          else if (b && t[1:0] != 2'b00) m_state = MFault;
          else begin
            m_pc = b ? t : m_pc + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          end
        end
      end
      default: ;
    endcase
    sb_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_pc",     inst_address,   e.pc);
    check("sb_valid",  instr_valid,    e.valid);
    check("sb_instr",  instr_out,      e.instr);
    check("sb_pc4",    pc_plus4,       e.p4);
    check("sb_pc8",    pc_plus8,       e.p8);
    check("sb_halted", halted,         e.halted);
    check("sb_err",    misaligned_err, e.err);
    check("sb_cnt",    fetch_count,    e.cnt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;

    // Reset state and BOOT -> RUN
    do_reset();
    check("rst_pc",     inst_address,   RV);
    check("rst_valid",  instr_valid,    1'b0);
    check("rst_pc8",    pc_plus8,       32'h20004008);
    check("rst_halted", halted,         1'b0);
    check("rst_err",    misaligned_err, 1'b0);
    check("rst_cnt",    fetch_count,    16'd0);
    step(1'b0, 1'b0, 32'h0);
    check("boot_valid", instr_valid,  1'b1);
    check("boot_pc",    inst_address, RV);

    // Free-run to the zero word at 0x20004034, then stay halted
    repeat (14) step(1'b0, 1'b0, 32'h0);
    check("halt_flag", halted,       1'b1);
    check("halt_pc",   inst_address, 32'h20004034);
    check("halt_cnt",  fetch_count,  16'd13);
    step(1'b0, 1'b1, RV);
    step(1'b1, 1'b0, 32'h0);
    check("halt_frozen", inst_address, 32'h20004034);

    // Branch at 0x20004008 to 0x20004020
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    check("br_at", inst_address, 32'h20004008);
    step(1'b0, 1'b1, 32'h20004020);
    check("br_pc", inst_address, 32'h20004020);
    step(1'b0, 1'b0, 32'h0);
    check("br_next", inst_address, 32'h20004024);

    // Stall with branch held for three cycles, then release
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b1, 1'b1, 32'h20004028);
    check("stall_pc",  inst_address, 32'h20004010);
    check("stall_cnt", fetch_count,  16'd4);
    step(1'b0, 1'b1, 32'h20004028);
    check("unstall_pc",  inst_address, 32'h20004028);
    check("unstall_cnt", fetch_count,  16'd5);

    // Misaligned branch target faults and sticks until reset
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h20004002);
    check("flt_err",   misaligned_err, 1'b1);
    check("flt_pc",    inst_address,   RV);
    check("flt_valid", instr_valid,    1'b0);
    step(1'b0, 1'b1, RV);
    step(1'b0, 1'b0, 32'h0);
    check("flt_sticky", misaligned_err, 1'b1);
    do_reset();
    check("flt_clear", misaligned_err, 1'b0);

    // HALT_ON_ZERO=0 build: wrap at 2^32, counter saturation, async reset
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFFFFFC);
    check("nz_pc_top", nz_inst_address, 32'hFFFFFFFC);
    check("nz_pc4",    nz_pc_plus4,     32'h0);
    check("nz_pc8",    nz_pc_plus8,     32'h4);
    step(1'b0, 1'b0, 32'h0);
    check("nz_wrap",   nz_inst_address, 32'h0);
    check("nz_valid",  nz_instr_valid,  1'b1);
    check("nz_instr",  nz_instr_out,    32'h0);
    check("nz_halted", nz_halted,       1'b0);
    repeat (16) step(1'b0, 1'b0, 32'h0);
    check("nz_sat",    nz_fetch_count,  4'hF);
    check("nz_err",    nz_misaligned_err, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_pc",     inst_address,    RV);
    check("async_halted", halted,          1'b0);
    check("async_nz_pc",  nz_inst_address, RV);
    check("async_nz_cnt", nz_fetch_count,  4'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
